rv_decode_stage: RTL and testbench

- Parametrised RISC-V decode/operand-fetch stage between fetch and execute.
- Drives an external register file and generates immediates for all base formats, sign-extended to XLEN.
- Forwards both source operands from the EXE, MEM and WB stages.
- Detects load-use hazards, holds fetch after control-flow instructions for a programmable shadow, and latches the execute pipeline register under a valid/stall handshake with flush.

---
 rtl/rv_decode_stage.sv | 178 +++++++++++++++++
 tb/tb_rv_decode_stage.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_decode_stage.sv
// RISC-V decode / operand-fetch stage: immediate generation, three-source operand
// forwarding, load-use and control-flow shadow holds, and the execute pipeline latch.
module rv_decode_stage #(
  parameter int XLEN      = 64,
  parameter int BR_SHADOW = 2
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            DE_V,
  input  logic [31:0]     DE_IR,
  input  logic [XLEN-1:0] DE_NPC,
  output logic            DE_READY,
  output logic [4:0]      RF_RS1_ADDR,
  output logic [4:0]      RF_RS2_ADDR,
  input  logic [XLEN-1:0] RF_RS1_DATA,
  input  logic [XLEN-1:0] RF_RS2_DATA,
  input  logic            EXF_V,
  input  logic [4:0]      EXF_RD,
  input  logic [XLEN-1:0] EXF_DATA,
  input  logic            EXF_IS_LD,
  input  logic            MEMF_V,
  input  logic [4:0]      MEMF_RD,
  input  logic [XLEN-1:0] MEMF_DATA,
  input  logic            WBF_V,
  input  logic [4:0]      WBF_RD,
  input  logic [XLEN-1:0] WBF_DATA,
  input  logic            EXE_STALL,
  input  logic            FLUSH,
  output logic            EXE_V,
  output logic [31:0]     EXE_IR,
  output logic [XLEN-1:0] EXE_NPC,
  output logic [XLEN-1:0] EXE_ALU_ONE,
  output logic [XLEN-1:0] EXE_ALU_TWO,
  output logic [XLEN-1:0] EXE_ST_DATA,
  output logic            EXE_ECALL
);

  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;
  localparam logic [31:0] ECALL_IR   = 32'h0000_0073;
  localparam int SH_W = (BR_SHADOW > 0) ? $clog2(BR_SHADOW + 1) : 1;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic signed [31:0] s;
    s = v;
    return XLEN'(s);
  endfunction

  function automatic logic [XLEN-1:0] fwd(
    input logic [4:0] a, input logic [XLEN-1:0] rf,
    input logic ex_v, input logic ex_ld, input logic [4:0] ex_rd, input logic [XLEN-1:0] ex_d,
    input logic mem_v, input logic [4:0] mem_rd, input logic [XLEN-1:0] mem_d,
    input logic wb_v, input logic [4:0] wb_rd, input logic [XLEN-1:0] wb_d);
    if (a == 5'd0)                          return '0;
    else if (ex_v && !ex_ld && ex_rd == a)  return ex_d;
    else if (mem_v && mem_rd == a)          return mem_d;
    else if (wb_v && wb_rd == a)            return wb_d;
    else                                    return rf;
  endfunction

  logic [6:0]      opc;
  logic [4:0]      rs1, rs2;
  logic            use_rs1, use_rs2, is_cf, is_shift, is_reg_op, load_use, accept;
  logic [XLEN-1:0] imm, rs1_val, rs2_val, op_a, op_b;

  logic            exe_v_q, exe_v_d, exe_ecall_q, exe_ecall_d;
  logic [31:0]     exe_ir_q, exe_ir_d;
  logic [XLEN-1:0] exe_npc_q, exe_npc_d, exe_a_q, exe_a_d, exe_b_q, exe_b_d, exe_st_q, exe_st_d;
  logic [SH_W-1:0] sh_q, sh_d;

  assign opc         = DE_IR[6:0];
  assign rs1         = DE_IR[19:15];
  assign rs2         = DE_IR[24:20];
  assign RF_RS1_ADDR = rs1;
  assign RF_RS2_ADDR = rs2;

  assign use_rs1   = !(opc == OPC_LUI || opc == OPC_AUIPC || opc == OPC_JAL);
  assign use_rs2   = (opc == OPC_OP || opc == OPC_OP32 || opc == OPC_STORE || opc == OPC_BRANCH);
  assign is_cf     = (opc == OPC_BRANCH || opc == OPC_JAL || opc == OPC_JALR);
  assign is_shift  = (DE_IR[13:12] == 2'b01);
  assign is_reg_op = (opc == OPC_OP || opc == OPC_OP32);

  assign load_use = EXF_V && EXF_IS_LD && (EXF_RD != 5'd0) &&
                    ((use_rs1 && EXF_RD == rs1) || (use_rs2 && EXF_RD == rs2));

  assign DE_READY = !RESET && !FLUSH && !EXE_STALL && !load_use && (sh_q == '0);
  assign accept   = DE_V && DE_READY;

  assign rs1_val = fwd(rs1, RF_RS1_DATA, EXF_V, EXF_IS_LD, EXF_RD, EXF_DATA,
                       MEMF_V, MEMF_RD, MEMF_DATA, WBF_V, WBF_RD, WBF_DATA);
  assign rs2_val = fwd(rs2, RF_RS2_DATA, EXF_V, EXF_IS_LD, EXF_RD, EXF_DATA,
                       MEMF_V, MEMF_RD, MEMF_DATA, WBF_V, WBF_RD, WBF_DATA);

  always_comb begin
    imm = sext32({{20{DE_IR[31]}}, DE_IR[31:20]});
    case (opc)
      OPC_STORE:            imm = sext32({{20{DE_IR[31]}}, DE_IR[31:25], DE_IR[11:7]});
      OPC_BRANCH:           imm = sext32({{19{DE_IR[31]}}, DE_IR[31], DE_IR[7], DE_IR[30:25],
                                          DE_IR[11:8], 1'b0});
      OPC_LUI, OPC_AUIPC:   imm = sext32({DE_IR[31:12], 12'h000});
      OPC_JAL:              imm = sext32({{11{DE_IR[31]}}, DE_IR[31], DE_IR[19:12], DE_IR[20],
                                          DE_IR[30:21], 1'b0});
      OPC_OPIMM:   if (is_shift) imm = (XLEN == 64) ? XLEN'(DE_IR[25:20]) : XLEN'(DE_IR[24:20]);
      OPC_OPIMM32: if (is_shift) imm = XLEN'(DE_IR[24:20]);
      default: ;
    endcase
  end

  // Only register-register ops take rs2 as operand B; branch compare data rides on EXE_ST_DATA.
  assign op_b = is_reg_op ? rs2_val : imm;
  assign op_a = (opc == OPC_AUIPC || opc == OPC_JAL) ? DE_NPC - XLEN'(4) : rs1_val;

  always_comb begin
    exe_v_d     = exe_v_q;
    exe_ir_d    = exe_ir_q;
    exe_npc_d   = exe_npc_q;
    exe_a_d     = exe_a_q;
    exe_b_d     = exe_b_q;
    exe_st_d    = exe_st_q;
    exe_ecall_d = exe_ecall_q;
    sh_d        = (sh_q != '0) ? sh_q - SH_W'(1) : sh_q;
    if (FLUSH) begin
      exe_v_d = 1'b0;
      sh_d    = '0;
    end else if (!EXE_STALL) begin
      // A refused or absent instruction (including a load-use hold) becomes a bubble.
      exe_v_d = accept;
      if (accept) begin
        exe_ir_d    = DE_IR;
        exe_npc_d   = DE_NPC;
        exe_a_d     = op_a;
        exe_b_d     = op_b;
        exe_st_d    = rs2_val;
        exe_ecall_d = (DE_IR == ECALL_IR);
        if (is_cf) sh_d = SH_W'(BR_SHADOW);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      exe_v_q     <= 1'b0;
      exe_ir_q    <= '0;
      exe_npc_q   <= '0;
      exe_a_q     <= '0;
      exe_b_q     <= '0;
      exe_st_q    <= '0;
      exe_ecall_q <= 1'b0;
      sh_q        <= '0;
    end else begin
      exe_v_q     <= exe_v_d;
      exe_ir_q    <= exe_ir_d;
      exe_npc_q   <= exe_npc_d;
      exe_a_q     <= exe_a_d;
      exe_b_q     <= exe_b_d;
      exe_st_q    <= exe_st_d;
      exe_ecall_q <= exe_ecall_d;
      sh_q        <= sh_d;
    end
  end

  assign EXE_V       = exe_v_q;
  assign EXE_IR      = exe_ir_q;
  assign EXE_NPC     = exe_npc_q;
  assign EXE_ALU_ONE = exe_a_q;
  assign EXE_ALU_TWO = exe_b_q;
  assign EXE_ST_DATA = exe_st_q;
  assign EXE_ECALL   = exe_ecall_q;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Bench for rv_decode_stage (XLEN=64, BR_SHADOW=2): directed scenarios plus random
// traffic compared against an instruction-level reference model.
module tb_rv_decode_stage;
  localparam int XLEN      = 64;
  localparam int BR_SHADOW = 2;

  logic            CLK = 1'b0;
  logic            RESET, DE_V, DE_READY;
  logic [31:0]     DE_IR;
  logic [63:0]     DE_NPC;
  logic [4:0]      RF_RS1_ADDR, RF_RS2_ADDR;
  logic [63:0]     RF_RS1_DATA, RF_RS2_DATA;
  logic            EXF_V, EXF_IS_LD, MEMF_V, WBF_V;
  logic [4:0]      EXF_RD, MEMF_RD, WBF_RD;
  logic [63:0]     EXF_DATA, MEMF_DATA, WBF_DATA;
  logic            EXE_STALL, FLUSH;
  logic            EXE_V, EXE_ECALL;
  logic [31:0]     EXE_IR;
  logic [63:0]     EXE_NPC, EXE_ALU_ONE, EXE_ALU_TWO, EXE_ST_DATA;

  logic [63:0] rf [32];
  assign RF_RS1_DATA = rf[RF_RS1_ADDR];
  assign RF_RS2_DATA = rf[RF_RS2_ADDR];

  int total = 0;
  int bad   = 0;

  // reference state: what the execute latch should hold, and remaining shadow cycles
  logic        m_v, m_ecall;
  logic [31:0] m_ir;
  logic [63:0] m_npc, m_a, m_b, m_st;
  int          m_sh;
  logic        obs_ready;

  always #5 CLK = ~CLK;

  rv_decode_stage #(.XLEN(XLEN), .BR_SHADOW(BR_SHADOW)) dut (
    .CLK(CLK), .RESET(RESET), .DE_V(DE_V), .DE_IR(DE_IR), .DE_NPC(DE_NPC),
    .DE_READY(DE_READY), .RF_RS1_ADDR(RF_RS1_ADDR), .RF_RS2_ADDR(RF_RS2_ADDR),
    .RF_RS1_DATA(RF_RS1_DATA), .RF_RS2_DATA(RF_RS2_DATA),
    .EXF_V(EXF_V), .EXF_RD(EXF_RD), .EXF_DATA(EXF_DATA), .EXF_IS_LD(EXF_IS_LD),
    .MEMF_V(MEMF_V), .MEMF_RD(MEMF_RD), .MEMF_DATA(MEMF_DATA),
    .WBF_V(WBF_V), .WBF_RD(WBF_RD), .WBF_DATA(WBF_DATA),
    .EXE_STALL(EXE_STALL), .FLUSH(FLUSH), .EXE_V(EXE_V), .EXE_IR(EXE_IR),
    .EXE_NPC(EXE_NPC), .EXE_ALU_ONE(EXE_ALU_ONE), .EXE_ALU_TWO(EXE_ALU_TWO),
    .EXE_ST_DATA(EXE_ST_DATA), .EXE_ECALL(EXE_ECALL)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // instruction encoders
  function automatic logic [31:0] enc_r(input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {7'h00, rs2, rs1, 3'b000, rd, op};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] off, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {off[12], off[10:5], rs2, rs1, 3'b000, off[4:1], off[11], 7'h63};
  endfunction

  // reference rules, written per instruction format
  function automatic bit reads_rs1(input logic [6:0] op);
    return !(op == 7'h37 || op == 7'h17 || op == 7'h6F);
  endfunction
  function automatic bit reads_rs2(input logic [6:0] op);
    return (op == 7'h33 || op == 7'h3B || op == 7'h23 || op == 7'h63);
  endfunction

  function automatic logic [63:0] m_imm(input logic [31:0] ir);
    logic [6:0] op;
    logic [2:0] f3;
    op = ir[6:0];
    f3 = ir[14:12];
    case (op)
      7'h37, 7'h17: return 64'($signed({ir[31:12], 12'h000}));
      7'h6F:        return 64'($signed({ir[31], ir[19:12], ir[20], ir[30:21], 1'b0}));
      7'h63:        return 64'($signed({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}));
      7'h23:        return 64'($signed({ir[31:25], ir[11:7]}));
      7'h13:        if (f3 == 3'd1 || f3 == 3'd5) return 64'(ir[25:20]);
      7'h1B:        if (f3 == 3'd1 || f3 == 3'd5) return 64'(ir[24:20]);
      default: ;
    endcase
    return 64'($signed(ir[31:20]));
  endfunction

  function automatic logic [63:0] m_fwd(input logic [4:0] a);
    if (a == 5'd0) return 64'd0;
    if (EXF_V && !EXF_IS_LD && EXF_RD == a) return EXF_DATA;
    if (MEMF_V && MEMF_RD == a) return MEMF_DATA;
    if (WBF_V && WBF_RD == a) return WBF_DATA;
    return rf[a];
  endfunction

  // One clock: check combinational outputs mid-cycle, advance the model, check the latch.
  task automatic cycle();
    logic [6:0] op;
    logic [4:0] s1, s2;
    bit lu, rdy;
    @(negedge CLK);
    op = DE_IR[6:0];
    s1 = DE_IR[19:15];
    s2 = DE_IR[24:20];
    lu = EXF_V && EXF_IS_LD && EXF_RD != 5'd0 &&
         ((reads_rs1(op) && EXF_RD == s1) || (reads_rs2(op) && EXF_RD == s2));
    rdy = !RESET && !FLUSH && !EXE_STALL && !lu && m_sh == 0;
    obs_ready = DE_READY;
    chk("de_ready", 64'(DE_READY), 64'(rdy));
    chk("rf_rs1_addr", 64'(RF_RS1_ADDR), 64'(s1));
    chk("rf_rs2_addr", 64'(RF_RS2_ADDR), 64'(s2));
    if (RESET) begin
      m_v = 0; m_ir = 0; m_npc = 0; m_a = 0; m_b = 0; m_st = 0; m_ecall = 0; m_sh = 0;
    end else if (FLUSH) begin
      m_v = 0; m_sh = 0;
    end else begin
      if (m_sh > 0) m_sh--;
      if (!EXE_STALL) begin
        m_v = DE_V && rdy;
        if (m_v) begin
          m_ir    = DE_IR;
          m_npc   = DE_NPC;
          m_a     = (op == 7'h17 || op == 7'h6F) ? DE_NPC - 64'd4 : m_fwd(s1);
          m_b     = (op == 7'h33 || op == 7'h3B) ? m_fwd(s2) : m_imm(DE_IR);
          m_st    = m_fwd(s2);
          m_ecall = (DE_IR == 32'h0000_0073);
          if (op == 7'h63 || op == 7'h6F || op == 7'h67) m_sh = BR_SHADOW;
        end
      end
    end
    @(posedge CLK);
    #1;
    chk("exe_v", 64'(EXE_V), 64'(m_v));
    chk("exe_ir", 64'(EXE_IR), 64'(m_ir));
    chk("exe_npc", EXE_NPC, m_npc);
    chk("exe_alu_one", EXE_ALU_ONE, m_a);
    chk("exe_alu_two", EXE_ALU_TWO, m_b);
    chk("exe_st_data", EXE_ST_DATA, m_st);
    chk("exe_ecall", 64'(EXE_ECALL), 64'(m_ecall));
  endtask

  function automatic logic [31:0] rand_ir();
    logic [6:0] ops [11];
    logic [31:0] ir;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h1B, 7'h3B};
    if ($urandom_range(0, 15) == 0) return 32'h0000_0073;
    ir = $urandom;
    ir[6:0] = ops[$urandom_range(0, 10)];
    ir[19:15] = 5'($urandom_range(0, 7));
    if ($urandom_range(0, 1) == 0) ir[24:20] = 5'($urandom_range(0, 7));
    return ir;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] snap_ir;
    logic [63:0] snap_a, snap_b;
    RESET = 1; DE_V = 0; DE_IR = 32'h0000_0013; DE_NPC = 64'h0;
    EXF_V = 0; EXF_RD = 0; EXF_DATA = 0; EXF_IS_LD = 0;
    MEMF_V = 0; MEMF_RD = 0; MEMF_DATA = 0; WBF_V = 0; WBF_RD = 0; WBF_DATA = 0;
    EXE_STALL = 0; FLUSH = 0;
    rf[0] = 64'hBAD0_BAD0_BAD0_BAD0;
    for (int i = 1; i < 32; i++) rf[i] = {$urandom, $urandom};
    m_v = 0; m_ir = 0; m_npc = 0; m_a = 0; m_b = 0; m_st = 0; m_ecall = 0; m_sh = 0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_ready", 64'(DE_READY), 64'd0);
    chk("rst_exe_v", 64'(EXE_V), 64'd0);
    chk("rst_exe_ir", 64'(EXE_IR), 64'd0);
    chk("rst_alu_one", EXE_ALU_ONE, 64'd0);
    chk("rst_ecall", 64'(EXE_ECALL), 64'd0);
    RESET = 0;

    // forwarding priority EXF > MEMF > WBF
    EXF_V = 1; EXF_RD = 5; EXF_DATA = 64'd10;
    MEMF_V = 1; MEMF_RD = 5; MEMF_DATA = 64'd20;
    WBF_V = 1; WBF_RD = 5; WBF_DATA = 64'd30;
    DE_V = 1; DE_NPC = 64'h1004; DE_IR = enc_r(5, 5, 6, 7'h33);
    cycle();
    chk("fwd_exf_a", EXE_ALU_ONE, 64'd10);
    chk("fwd_exf_b", EXE_ALU_TWO, 64'd10);
    EXF_V = 0;
    cycle();
    chk("fwd_mem_a", EXE_ALU_ONE, 64'd20);
    chk("fwd_mem_b", EXE_ALU_TWO, 64'd20);
    MEMF_V = 0;
    cycle();
    chk("fwd_wb_a", EXE_ALU_ONE, 64'd30);
    chk("fwd_wb_b", EXE_ALU_TWO, 64'd30);
    WBF_V = 0;

    // x0 never forwarded
    EXF_V = 1; EXF_RD = 0; EXF_DATA = 64'hDEAD;
    DE_IR = enc_i(12'd5, 0, 3'b000, 1, 7'h13);
    cycle();
    chk("x0_alu_one", EXE_ALU_ONE, 64'd0);
    chk("x0_alu_two", EXE_ALU_TWO, 64'd5);

    // load-use: one bubble, then MEMF supplies the loaded value
    EXF_V = 1; EXF_IS_LD = 1; EXF_RD = 7;
    DE_IR = enc_r(1, 7, 8, 7'h33);
    cycle();
    chk("lu_ready", 64'(obs_ready), 64'd0);
    chk("lu_bubble", 64'(EXE_V), 64'd0);
    EXF_V = 0; EXF_IS_LD = 0; MEMF_V = 1; MEMF_RD = 7; MEMF_DATA = 64'h77;
    cycle();
    chk("lu_after_ready", 64'(obs_ready), 64'd1);
    chk("lu_after_v", 64'(EXE_V), 64'd1);
    chk("lu_after_a", EXE_ALU_ONE, 64'h77);
    MEMF_V = 0;

    // immediates and branch shadow
    DE_IR = enc_b(13'h1FFC, 2, 1);
    cycle();
    chk("beq_imm", EXE_ALU_TWO, 64'hFFFF_FFFF_FFFF_FFFC);
    DE_IR = enc_i(12'h03F, 1, 3'b001, 3, 7'h13);
    cycle();
    chk("shadow_1", 64'(obs_ready), 64'd0);
    cycle();
    chk("shadow_2", 64'(obs_ready), 64'd0);
    cycle();
    chk("shadow_end", 64'(obs_ready), 64'd1);
    chk("slli_shamt", EXE_ALU_TWO, 64'd63);
    DE_IR = {20'h80000, 5'd4, 7'h37};
    cycle();
    chk("lui_imm", EXE_ALU_TWO, 64'hFFFF_FFFF_8000_0000);

    // flush inside the shadow
    DE_IR = enc_b(13'h0010, 3, 4);
    cycle();
    FLUSH = 1;
    cycle();
    chk("flush_ready", 64'(obs_ready), 64'd0);
    chk("flush_v", 64'(EXE_V), 64'd0);
    FLUSH = 0;
    DE_IR = enc_i(12'h123, 2, 3'b000, 9, 7'h13);
    cycle();
    chk("post_flush_ready", 64'(obs_ready), 64'd1);
    chk("post_flush_v", 64'(EXE_V), 64'd1);

    // stall holds the latch; flush overrides stall
    snap_ir = EXE_IR; snap_a = EXE_ALU_ONE; snap_b = EXE_ALU_TWO;
    EXE_STALL = 1;
    DE_IR = enc_r(3, 4, 10, 7'h33);
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("stall_ir", 64'(EXE_IR), 64'(snap_ir));
      chk("stall_a", EXE_ALU_ONE, snap_a);
      chk("stall_b", EXE_ALU_TWO, snap_b);
      chk("stall_v", 64'(EXE_V), 64'd1);
    end
    FLUSH = 1;
    cycle();
    chk("stall_flush_v", 64'(EXE_V), 64'd0);
    FLUSH = 0; EXE_STALL = 0;

    // ECALL flag
    DE_IR = 32'h0000_0073;
    cycle();
    chk("ecall", 64'(EXE_ECALL), 64'd1);

    // reset mid-stream
    DE_IR = enc_r(3, 4, 10, 7'h33);
    cycle();
    RESET = 1;
    cycle();
    chk("midrst_ready", 64'(obs_ready), 64'd0);
    chk("midrst_v", 64'(EXE_V), 64'd0);
    chk("midrst_ir", 64'(EXE_IR), 64'd0);
    chk("midrst_two", EXE_ALU_TWO, 64'd0);
    chk("midrst_st", EXE_ST_DATA, 64'd0);
    RESET = 0;

    // random traffic against the reference model
    for (int n = 0; n < 500; n++) begin
      RESET     = ($urandom_range(0, 99) < 2);
      FLUSH     = ($urandom_range(0, 99) < 8);
      EXE_STALL = ($urandom_range(0, 99) < 20);
      DE_V      = ($urandom_range(0, 99) < 80);
      DE_IR     = rand_ir();
      DE_NPC    = {$urandom, $urandom};
      EXF_V     = 1'($urandom_range(0, 1));
      EXF_RD    = 5'($urandom_range(0, 7));
      EXF_DATA  = {$urandom, $urandom};
      EXF_IS_LD = ($urandom_range(0, 3) == 0);
      MEMF_V    = 1'($urandom_range(0, 1));
      MEMF_RD   = 5'($urandom_range(0, 7));
      MEMF_DATA = {$urandom, $urandom};
      WBF_V     = 1'($urandom_range(0, 1));
      WBF_RD    = 5'($urandom_range(0, 7));
      WBF_DATA  = {$urandom, $urandom};
      rf[$urandom_range(1, 31)] = {$urandom, $urandom};
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
